uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter serialising one parallel byte per request onto a single line: start bit, DATA_WIDTH data bits LSB-first, optional parity, STOP_WIDTH stop bits. Sits beside `uart_rx` and shares its baud tick from `br_generator` (16 ticks per bit). Its `o_tx` output drives `uart_rx.i_rx_data` directly in loopback.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `STOP_WIDTH`, 1: stop bits per frame, range 1–2.
- `OVERSAMPLE`, 16: `i_tick` pulses per bit period.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_tick` in 1: baud tick from `br_generator`, one `clk` cycle wide.
- `i_tx_start` in 1: request to send `i_data_byte`.
- `i_data_byte` in DATA_WIDTH: byte to send; sampled only when the start is accepted.
- `o_tx` out 1: serial line; idle high.
- `o_tx_busy` out 1: high from acceptance until the frame ends.
- `o_tx_done_bit` out 1: one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done_bit`=0, state IDLE, all counters and the shift register 0.
- States:
  - IDLE: if `i_tx_start`=1, latch `i_data_byte`, clear the tick counter, go to START.
  - START: `o_tx`=0 for OVERSAMPLE ticks, then go to DATA with bit index 0.
  - DATA: `o_tx`=shift[0] for OVERSAMPLE ticks, then shift right and increment the bit index. After bit DATA_WIDTH-1, go to PARITY if enabled, else STOP.
  - PARITY: see Configuration.
  - STOP: `o_tx`=1 for OVERSAMPLE×STOP_WIDTH ticks, then go to IDLE and pulse `o_tx_done_bit`.
- Tick counter: width $clog2(OVERSAMPLE×2). It advances only on `i_tick`=1 and clears at every state change.
- Bit index: width $clog2(DATA_WIDTH).
- `o_tx` is registered and glitch-free; it comes from the next-state value, not from combinational decode.
- `i_tx_start` while busy (any state except IDLE) is ignored. It is not queued. The latched byte is not disturbed.
- `i_tx_start` held high continuously: the next frame is accepted in the first IDLE cycle after `o_tx_done_bit`. Frames go back to back with no extra idle bit.
- `i_data_byte` changes after acceptance have no effect on the frame.
- `reset` asserted mid-frame: the state machine returns to IDLE and `o_tx` goes to 1 immediately (asynchronous). No done pulse is produced.

## Timing
- Acceptance cycle: `i_tx_start` is sampled at edge N. At edge N, `o_tx` falls to 0 and `o_tx_busy` rises.
- Each bit lasts exactly OVERSAMPLE `i_tick` pulses. The bit boundary is the `clk` edge on which the 16th tick is seen.
- Frame length in ticks: OVERSAMPLE × (1 + DATA_WIDTH + P + STOP_WIDTH), where P=1 with parity and 0 without. The default is 160 ticks.
- `o_tx_done_bit` and the fall of `o_tx_busy` occur on the same edge that ends the last stop bit.
- `i_tick` absent: the frame stalls with `o_tx` held at its current value.
- Example: 50 MHz `clk` and `br_generator` divide 163 give a bit period of 52160 ns. This is within 0.15% of 19200 baud.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. It drives even parity (XOR of the latched data bits) for OVERSAMPLE ticks between DATA and STOP.
- `UART_TX_PARITY_EN` undefined: the PARITY state, the parity register and their logic are absent. DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum type `uart_state_t` (IDLE, START, DATA, PARITY, STOP), shared with `uart_rx`;
  - the default constants `UART_DATA_WIDTH`=8, `UART_STOP_WIDTH`=1 and `UART_OVERSAMPLE`=16.
- No sub-module. The tick comes from the existing `br_generator`, instantiated at the top level and shared with `uart_rx`.

## Test plan
1. Reset → no start. Release `reset` and leave `i_tx_start`=0 for 200 ticks → `o_tx`=1, `o_tx_busy`=0, `o_tx_done_bit` never pulses.
2. Single frame. Start with byte 8'b01101010 → line reads 0, then 0,1,0,1,0,1,1,0, then 1. Each bit is 16 ticks. `o_tx_done_bit` pulses once after 160 ticks.
3. Loopback. `o_tx` → `uart_rx`, byte 8'hA5 → `uart_rx.o_data_byte`=8'hA5. `o_rx_done_bit` pulses before `o_tx_done_bit`.
4. Start while busy. Start with 8'h3C, then pulse start with 8'hFF during DATA → only 8'h3C is sent, with a single done pulse.
5. Back-to-back. Hold `i_tx_start` high with 8'h55, then 8'h0F → two frames with no idle gap between them and two done pulses.
6. Mid-frame reset. Assert `reset` during data bit 3 → `o_tx`=1 and `o_tx_busy`=0 immediately, with no done pulse. With `UART_TX_PARITY_EN`, byte 8'h07 → parity bit 1 and a 176-tick frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding used by uart_tx and uart_rx,
// plus the default frame constants.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_STOP_WIDTH = 1;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even
// parity, STOP_WIDTH stop bits. Each bit lasts OVERSAMPLE baud ticks.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
//
// state  | meaning
// IDLE   | line high, waiting for i_tx_start
// START  | line low for one bit period
// DATA   | shifting out latched byte, LSB first
// PARITY | even parity of latched byte (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_WIDTH bit periods, then done pulse
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int STOP_WIDTH = UART_STOP_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tick,
  input  logic                  i_tx_start,
  input  logic [DATA_WIDTH-1:0] i_data_byte,
  output logic                  o_tx,
  output logic                  o_tx_busy,
  output logic                  o_tx_done_bit
);

  localparam int CNT_W = $clog2(OVERSAMPLE * 2);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(OVERSAMPLE * STOP_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state_q, state_d;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_d;
  logic                  done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // State and datapath registers; line level and flags come from next-state values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      o_tx          <= 1'b1;
      o_tx_busy     <= 1'b0;
      o_tx_done_bit <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      o_tx          <= tx_d;
      o_tx_busy     <= (state_d != IDLE);
      o_tx_done_bit <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  // Next-state, tick counting and next line level
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = o_tx;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          shift_d  = i_data_byte;
          tick_d   = '0;
          state_d  = START;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_data_byte;
`endif
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            idx_d   = '0;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
              tx_d  = shift_d[0];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_q == BIT_LAST) begin
            state_d = STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (i_tick) begin
          if (tick_q == STOP_LAST) begin
            state_d = IDLE;
            tick_d  = '0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: drives baud ticks with random spacing, records the
// line level at every tick and compares each bit period against a frame
// built from the data byte.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS  = 1 + DW + PB + 1;
  localparam int FRAME_TICKS = OS * FRAME_BITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_tick;
  logic          i_tx_start;
  logic [DW-1:0] i_data_byte;
  logic          o_tx;
  logic          o_tx_busy;
  logic          o_tx_done_bit;

  int tests_run = 0;
  int failed    = 0;
  int done_cnt  = 0;
  logic cap [0:255];

  always #5 clk = ~clk;

  uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .i_tick       (i_tick),
    .i_tx_start   (i_tx_start),
    .i_data_byte  (i_data_byte),
    .o_tx         (o_tx),
    .o_tx_busy    (o_tx_busy),
    .o_tx_done_bit(o_tx_done_bit)
  );

  // Count every cycle the done flag is high
  always @(posedge clk) begin
    #2;
    if (o_tx_done_bit === 1'b1) done_cnt++;
  end

  // Expected frame, bit 0 first on the line
  function automatic logic [FRAME_BITS-1:0] model_frame(input logic [DW-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DW] = ^d;
`endif
    return f;
  endfunction

  // Per-bit line level from captured ticks; X where a bit period was not constant
  function automatic logic [FRAME_BITS-1:0] observed_frame();
    logic [FRAME_BITS-1:0] r;
    logic v;
    for (int b = 0; b < FRAME_BITS; b++) begin
      v = cap[b*OS];
      for (int i = 1; i < OS; i++) if (cap[b*OS+i] !== v) v = 1'bx;
      r[b] = v;
    end
    return r;
  endfunction

  // Receiver view: sample each data bit mid-period
  function automatic logic [DW-1:0] rx_decode();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = cap[(1+i)*OS + OS/2];
    return r;
  endfunction

  task automatic do_tick(input int gap, output logic line);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    line = o_tx;
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic run_ticks(input int first, input int n);
    logic line;
    for (int k = 0; k < n; k++) begin
      do_tick($urandom_range(0, 2), line);
      cap[first+k] = line;
    end
  endtask

  task automatic start_frame(input logic [DW-1:0] d, input bit hold);
    @(negedge clk);
    i_data_byte = d;
    i_tx_start  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) i_tx_start = 1'b0;
    i_data_byte = DW'($urandom);
  endtask

  task automatic test_reset();
    int ones;
    reset = 1'b0; i_tick = 1'b0; i_tx_start = 1'b0; i_data_byte = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_bit !== 1'b0) begin
      failed++;
      $display("FAIL reset_values: tx=%b busy=%b done=%b, want 1 0 0", o_tx, o_tx_busy, o_tx_done_bit);
    end
    reset = 1'b1;
    run_ticks(0, 200);
    ones = 0;
    for (int i = 0; i < 200; i++) if (cap[i] === 1'b1) ones++;
    tests_run++;
    if (ones != 200 || o_tx_busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_line: high ticks=%0d busy=%b, want 200 0", ones, o_tx_busy);
    end
    tests_run++;
    if (done_cnt != 0) begin
      failed++;
      $display("FAIL idle_no_done: done pulses=%0d, want 0", done_cnt);
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] d;
    int d0;
    d = 8'b0110_1010;
    d0 = done_cnt;
    start_frame(d, 1'b0);
    tests_run++;
    if (o_tx !== 1'b0 || o_tx_busy !== 1'b1) begin
      failed++;
      $display("FAIL accept_edge: tx=%b busy=%b, want 0 1", o_tx, o_tx_busy);
    end
    run_ticks(0, FRAME_TICKS - 1);
    @(negedge clk);
    cap[FRAME_TICKS-1] = o_tx;
    tests_run++;
    if (o_tx_busy !== 1'b1 || done_cnt != d0) begin
      failed++;
      $display("FAIL before_last_tick: busy=%b done pulses=%0d, want 1 %0d", o_tx_busy, done_cnt - d0, 0);
    end
    i_tick = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (o_tx_done_bit !== 1'b1 || o_tx_busy !== 1'b0 || o_tx !== 1'b1) begin
      failed++;
      $display("FAIL frame_end_edge: done=%b busy=%b tx=%b, want 1 0 1", o_tx_done_bit, o_tx_busy, o_tx);
    end
    @(negedge clk);
    i_tick = 1'b0;
    tests_run++;
    if (observed_frame() !== model_frame(d)) begin
      failed++;
      $display("FAIL single_frame_bits: got %b want %b", observed_frame(), model_frame(d));
    end
    @(negedge clk);
    tests_run++;
    if (o_tx_done_bit !== 1'b0 || done_cnt != d0 + 1) begin
      failed++;
      $display("FAIL done_one_cycle: done=%b pulses=%0d, want 0 1", o_tx_done_bit, done_cnt - d0);
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic held;
    int d0, k, moved;
    for (int n = 0; n < 6; n++) begin
      d = (n == 0) ? 8'hA5 : DW'($urandom);
      d0 = done_cnt;
      start_frame(d, 1'b0);
      k = $urandom_range(1, FRAME_TICKS - 1);
      run_ticks(0, k);
      held = o_tx;
      moved = 0;
      repeat (40) begin
        @(negedge clk);
        if (o_tx !== held || o_tx_busy !== 1'b1) moved++;
      end
      tests_run++;
      if (moved != 0) begin
        failed++;
        $display("FAIL stall_hold: frame %0d changed in %0d stalled cycles, want 0", n, moved);
      end
      run_ticks(k, FRAME_TICKS - k);
      repeat (2) @(negedge clk);
      tests_run++;
      if (observed_frame() !== model_frame(d)) begin
        failed++;
        $display("FAIL random_frame_bits: byte %h got %b want %b", d, observed_frame(), model_frame(d));
      end
      tests_run++;
      if (rx_decode() !== d) begin
        failed++;
        $display("FAIL loopback_byte: got %h want %h", rx_decode(), d);
      end
      tests_run++;
      if (done_cnt != d0 + 1 || o_tx_busy !== 1'b0) begin
        failed++;
        $display("FAIL random_frame_done: pulses=%0d busy=%b, want 1 0", done_cnt - d0, o_tx_busy);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int d0;
    d0 = done_cnt;
    start_frame(8'h3C, 1'b0);
    run_ticks(0, 40);
    @(negedge clk);
    i_tx_start = 1'b1;
    i_data_byte = 8'hFF;
    @(negedge clk);
    i_tx_start = 1'b0;
    run_ticks(40, FRAME_TICKS - 40);
    repeat (20) @(negedge clk);
    tests_run++;
    if (observed_frame() !== model_frame(8'h3C)) begin
      failed++;
      $display("FAIL busy_start_bits: got %b want %b", observed_frame(), model_frame(8'h3C));
    end
    tests_run++;
    if (done_cnt != d0 + 1 || o_tx_busy !== 1'b0 || o_tx !== 1'b1) begin
      failed++;
      $display("FAIL busy_start_not_queued: pulses=%0d busy=%b tx=%b, want 1 0 1", done_cnt - d0, o_tx_busy, o_tx);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    start_frame(8'h55, 1'b1);
    run_ticks(0, FRAME_TICKS - 1);
    @(negedge clk);
    cap[FRAME_TICKS-1] = o_tx;
    i_tick = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (o_tx_done_bit !== 1'b1 || o_tx !== 1'b1) begin
      failed++;
      $display("FAIL b2b_first_end: done=%b tx=%b, want 1 1", o_tx_done_bit, o_tx);
    end
    tests_run++;
    if (observed_frame() !== model_frame(8'h55)) begin
      failed++;
      $display("FAIL b2b_first_bits: got %b want %b", observed_frame(), model_frame(8'h55));
    end
    @(negedge clk);
    i_tick = 1'b0;
    i_data_byte = 8'h0F;
    @(posedge clk);
    #1;
    tests_run++;
    if (o_tx_busy !== 1'b1 || o_tx !== 1'b0) begin
      failed++;
      $display("FAIL b2b_reaccept: busy=%b tx=%b, want 1 0", o_tx_busy, o_tx);
    end
    i_tx_start = 1'b0;
    i_data_byte = DW'($urandom);
    run_ticks(0, FRAME_TICKS);
    repeat (2) @(negedge clk);
    tests_run++;
    if (observed_frame() !== model_frame(8'h0F)) begin
      failed++;
      $display("FAIL b2b_second_bits: got %b want %b", observed_frame(), model_frame(8'h0F));
    end
    tests_run++;
    if (done_cnt != d0 + 2) begin
      failed++;
      $display("FAIL b2b_done_count: pulses=%0d, want 2", done_cnt - d0);
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    int d0, highs;
    d = DW'($urandom) & 8'hF7;
    d0 = done_cnt;
    start_frame(d, 1'b0);
    run_ticks(0, OS * 4 + 5);
    tests_run++;
    if (o_tx_busy !== 1'b1 || o_tx !== 1'b0) begin
      failed++;
      $display("FAIL pre_reset_bit3: busy=%b tx=%b, want 1 0", o_tx_busy, o_tx);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_bit !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: tx=%b busy=%b done=%b, want 1 0 0", o_tx, o_tx_busy, o_tx_done_bit);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_ticks(0, 40);
    @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) if (cap[i] === 1'b1) highs++;
    tests_run++;
    if (done_cnt != d0 || highs != 40 || o_tx_busy !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_idle: pulses=%0d high ticks=%0d busy=%b, want 0 40 0", done_cnt - d0, highs, o_tx_busy);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int d0;
    d0 = done_cnt;
    start_frame(8'h07, 1'b0);
    run_ticks(0, FRAME_TICKS - 1);
    @(negedge clk);
    tests_run++;
    if (o_tx_busy !== 1'b1 || cap[(1+DW)*OS] !== 1'b1) begin
      failed++;
      $display("FAIL parity_bit: busy=%b parity=%b, want 1 1", o_tx_busy, cap[(1+DW)*OS]);
    end
    run_ticks(FRAME_TICKS - 1, 1);
    @(negedge clk);
    tests_run++;
    if (done_cnt != d0 + 1 || o_tx_busy !== 1'b0) begin
      failed++;
      $display("FAIL parity_frame_len: pulses=%0d busy=%b, want 1 0", done_cnt - d0, o_tx_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
